// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// Optional golden-table compare is enabled with the TT_COMPARE_EN macro.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned N_IN_DFLT = 4;
  localparam int unsigned TABLE_W   = 2 ** N_IN_DFLT;

  function automatic int unsigned table_w(input int unsigned n_in);
    return 1 << n_in;
  endfunction

  // Hold counter must be able to hold the value HOLD_CYCLES itself.
  function automatic int unsigned hold_w(input int unsigned hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Hold timer: counts enabled cycles since clear; expire marks the
// HOLD_CYCLES-th enabled cycle.
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = hold_w(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN input vectors into a combinational DUT and records f_in
// into table_out. Define TT_COMPARE_EN to add golden-table error counting.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  output logic                 vec_valid,
  input  logic                 f_in,
  output logic                 sample,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out
`ifdef TT_COMPARE_EN
  ,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 mismatch,
  output logic [N_IN:0]        err_count
`endif
);

  localparam int unsigned TW = table_w(N_IN);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [TW-1:0]   table_q, table_d;
  logic            start_q;
  logic            accept;
  logic            tmr_clear, tmr_en, tmr_expire;

  // start is registered, so a request is acted on one edge after it is seen;
  // this sets the start-to-done latency at 1 + 2**N_IN*(HOLD_CYCLES+1).
  assign accept = start_q && ((state_q == IDLE) || (state_q == DONE));

  tt_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    table_d   = table_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d   = DRIVE;
          vec_d     = '0;
          table_d   = '0;
          tmr_clear = 1'b1;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[vec_q] = f_in;
        tmr_clear      = 1'b1;
        if (vec_q == '1) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      table_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      start_q <= start;
    end
  end

  assign vec       = vec_q;
  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign vec_valid = busy;
  assign sample    = (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign table_out = table_q;

`ifdef TT_COMPARE_EN
  logic [N_IN:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = '0;
    end else if ((state_q == SAMPLE) && (f_in != expected[vec_q]) && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
  assign mismatch  = (err_q != '0);
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper; golden-compare checks are
// included when TT_COMPARE_EN is defined.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  vec;
  logic        vec_valid;
  logic        f_in;
  logic        sample;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [15:0] golden;
`ifdef TT_COMPARE_EN
  logic        mismatch;
  logic [4:0]  err_count;
`endif

  int unsigned fsel;
  logic [15:0] rtab;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Reference functions fed back as the combinational DUT output.
  function automatic logic ref_f(input int unsigned sel, input logic [15:0] rt,
                                 input logic [3:0] k);
    case (sel)
      0:       return k[0] & k[1];
      1:       return ^k;
      2:       return 1'b0;
      3:       return k[0] | k[1];
      default: return rt[k];
    endcase
  endfunction

  assign f_in = ref_f(fsel, rtab, vec);

  truth_table_sweeper #(
    .N_IN(4),
    .HOLD_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vec      (vec),
    .vec_valid(vec_valid),
    .f_in     (f_in),
    .sample   (sample),
    .busy     (busy),
    .done     (done),
    .table_out(table_out)
`ifdef TT_COMPARE_EN
    ,
    .expected (golden),
    .mismatch (mismatch),
    .err_count(err_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int unsigned fsel;
    logic [15:0] rtab;
    logic [15:0] exp_tab;
    logic [15:0] gold;
    int unsigned poke;
  } vec_t;

  vec_t vecs[8];

  // One full sweep; poke < 16 pulses start while vec==poke mid-sweep.
  task automatic do_sweep(input string nm, input logic [15:0] exp_tab,
                          input logic [15:0] gold, input int unsigned poke);
    int unsigned cyc = 0;
    int unsigned nsamp = 0;
    bit          poked = 0;
    logic [3:0]  pv;
    logic        ps;
    golden = gold;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pv = vec;
    ps = sample;
    forever begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk({nm, "_busy_at_accept"}, {31'b0, busy}, 1);
        chk({nm, "_done_cleared"}, {31'b0, done}, 0);
        chk({nm, "_table_cleared"}, {16'b0, table_out}, 0);
        chk({nm, "_vec_start"}, {28'b0, vec}, 0);
      end else if (vec !== pv) begin
        chk({nm, "_vec_moves_after_sample"}, {31'b0, ps}, 1);
      end
      if (sample) begin
        chk({nm, "_sample_order"}, {28'b0, vec}, nsamp);
        nsamp++;
      end
      if (!poked && poke < 16 && busy && vec == poke[3:0]) begin
        start = 1'b1;
        poked = 1;
      end
      pv = vec;
      ps = sample;
      if ((cyc > 1 && done) || cyc >= 200) break;
    end
    chk({nm, "_latency"}, cyc, 49);
    chk({nm, "_sample_count"}, nsamp, 16);
    chk({nm, "_table"}, {16'b0, table_out}, {16'b0, exp_tab});
    chk({nm, "_idle_flags"}, {29'b0, busy, vec_valid, sample}, 0);
    chk({nm, "_vec_final"}, {28'b0, vec}, 15);
`ifdef TT_COMPARE_EN
    begin
      int unsigned nerr;
      nerr = $countones(exp_tab ^ gold);
      if (nerr > 31) nerr = 31;
      chk({nm, "_err_count"}, {27'b0, err_count}, nerr);
      chk({nm, "_mismatch"}, {31'b0, mismatch}, (nerr != 0) ? 1 : 0);
    end
`endif
  endtask

  initial begin
    int unsigned cyc;
    logic [15:0] e;
    rst    = 1'b1;
    start  = 1'b0;
    fsel   = 0;
    rtab   = '0;
    golden = '0;

    vecs[0] = '{0, 16'h0, 16'h8888, 16'h8888, 16};
    vecs[1] = '{1, 16'h0, 16'h6996, 16'h6996, 16};
    vecs[2] = '{2, 16'h0, 16'h0000, 16'h0000, 16};
    vecs[3] = '{2, 16'h0, 16'h0000, 16'h0000, 16};
    vecs[4] = '{3, 16'h0, 16'hEEEE, 16'h8888, 3};
    for (int i = 5; i < 8; i++) begin
      rtab = 16'($urandom);
      for (int k = 0; k < 16; k++) e[k] = ref_f(4, rtab, k[3:0]);
      vecs[i] = '{4, rtab, e, 16'($urandom), 16};
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {11'b0, vec, vec_valid, sample, busy, done, table_out}, 0);
`ifdef TT_COMPARE_EN
    chk("reset_err", {26'b0, mismatch, err_count}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", {29'b0, busy, done, vec_valid}, 0);

    for (int i = 0; i < 8; i++) begin
      fsel = vecs[i].fsel;
      rtab = vecs[i].rtab;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_sweep($sformatf("vec%0d", i), vecs[i].exp_tab, vecs[i].gold, vecs[i].poke);
    end

    // Reset in the middle of a sweep discards the partial table.
    fsel = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (vec !== 4'd5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midreset_reach_vec5", {28'b0, vec}, 5);
    chk("midreset_partial_table", {16'b0, table_out}, 32'h0008);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_outputs", {11'b0, vec, vec_valid, sample, busy, done, table_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_stays_idle", {29'b0, busy, done, vec_valid}, 0);

    do_sweep("after_reset", 16'h8888, 16'h8888, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
